// File: rtl/thor2025_pkg.sv
// Shared Thor2025 writeback definitions: default widths and the
// writeback-request bundle used between execute units and the register file.
package thor2025_pkg;

   localparam int THOR_WID  = 64;
   localparam int THOR_RBIT = 11;
   localparam int THOR_NREQ = 6;
   localparam int THOR_NPORT = 3;

   typedef struct packed {
      logic                 valid;
      logic [THOR_RBIT:0]   wa;
      logic [7:0]           we;
      logic [THOR_WID-1:0]  data;
   } wb_req_t;

   // Register 0 of every bank is hard-wired; writes to it are dropped.
   function automatic logic null_wa(input logic [5:0] a);
      return a == 6'd0;
   endfunction

endpackage

// File: rtl/thor2025_rr_pick3.sv
// Round-robin selection of up to three writeback requesters per cycle,
// suppressing a second grant to an address already granted this scan.
module thor2025_rr_pick3
   import thor2025_pkg::*;
#(
   parameter int NREQ = THOR_NREQ,
   parameter int RBIT = THOR_RBIT,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]          valid,
   input  logic [NREQ*(RBIT+1)-1:0] wa,
   input  logic [PW-1:0]            ptr,
   output logic [NREQ-1:0]          grant,
   output logic [PW-1:0]            idx0,
   output logic [PW-1:0]            idx1,
   output logic [PW-1:0]            idx2,
   output logic                     v0,
   output logic                     v1,
   output logic                     v2,
   output logic                     any,
   output logic [PW-1:0]            last
);

   localparam int A = RBIT + 1;

   int             ng;
   int             np;
   int             j;
   logic           dup;
   logic [RBIT:0]  a;

   always_comb begin
      grant = '0;
      idx0  = '0;
      idx1  = '0;
      idx2  = '0;
      v0    = 1'b0;
      v1    = 1'b0;
      v2    = 1'b0;
      any   = 1'b0;
      last  = ptr;
      ng    = 0;
      np    = 0;
      j     = 0;
      dup   = 1'b0;
      a     = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ)
            j = j - NREQ;
         a   = wa[j*A +: A];
         dup = 1'b0;
         for (int k = 0; k < NREQ; k++)
            if (grant[k] && wa[k*A +: A] == a)
               dup = 1'b1;
         if (valid[j] && !dup && ng < THOR_NPORT) begin
            grant[j] = 1'b1;
            ng       = ng + 1;
            any      = 1'b1;
            last     = PW'(j);
            // Null-register writes are consumed without taking a port.
            if (!null_wa(a[5:0])) begin
               unique case (np)
                  0: begin idx0 = PW'(j); v0 = 1'b1; end
                  1: begin idx1 = PW'(j); v1 = 1'b1; end
                  default: begin idx2 = PW'(j); v2 = 1'b1; end
               endcase
               np = np + 1;
            end
         end
      end
   end

endmodule

// File: rtl/thor2025_rf_wrport_sched.sv
// Register-file write-port scheduler: maps up to three writeback requests
// per cycle onto the three RF write ports, one cycle after grant.
module thor2025_rf_wrport_sched
   import thor2025_pkg::*;
#(
   parameter int WID  = THOR_WID,
   parameter int RBIT = THOR_RBIT,
   parameter int NREQ = THOR_NREQ
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*(RBIT+1)-1:0] req_wa,
   input  logic [NREQ*8-1:0]        req_we,
   input  logic [NREQ*WID-1:0]      req_data,
   output logic                     wr0,
   output logic                     wr1,
   output logic                     wr2,
   output logic [RBIT:0]            wa0,
   output logic [RBIT:0]            wa1,
   output logic [RBIT:0]            wa2,
   output logic [7:0]               we0,
   output logic [7:0]               we1,
   output logic [7:0]               we2,
   output logic [WID-1:0]           i0,
   output logic [WID-1:0]           i1,
   output logic [WID-1:0]           i2,
   output logic [31:0]              stall_cnt
);

   localparam int PW = $clog2(NREQ);
   localparam int A  = RBIT + 1;

   logic [PW-1:0]   rr_ptr;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] elig;
   logic [PW-1:0]   idx0;
   logic [PW-1:0]   idx1;
   logic [PW-1:0]   idx2;
   logic            v0;
   logic            v1;
   logic            v2;
   logic            any;
   logic [PW-1:0]   last;
   logic            waiting;

   assign elig      = req_valid & {NREQ{~stall}};
   assign req_ready = grant;
   assign waiting   = |(req_valid & ~req_ready);

   thor2025_rr_pick3 #(
      .NREQ (NREQ),
      .RBIT (RBIT),
      .PW   (PW)
   ) u_pick (
      .valid (elig),
      .wa    (req_wa),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx0  (idx0),
      .idx1  (idx1),
      .idx2  (idx2),
      .v0    (v0),
      .v1    (v1),
      .v2    (v2),
      .any   (any),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         stall_cnt <= '0;
      end else begin
         if (any)
            rr_ptr <= (last == PW'(NREQ-1)) ? '0 : last + 1'b1;
         if (waiting)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   // Unused ports keep their last address/data to avoid needless toggling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr0 <= 1'b0;
         wr1 <= 1'b0;
         wr2 <= 1'b0;
         wa0 <= '0;
         wa1 <= '0;
         wa2 <= '0;
         we0 <= '0;
         we1 <= '0;
         we2 <= '0;
         i0  <= '0;
         i1  <= '0;
         i2  <= '0;
      end else begin
         wr0 <= v0;
         wr1 <= v1;
         wr2 <= v2;
         if (v0) begin
            wa0 <= req_wa[int'(idx0)*A +: A];
            we0 <= req_we[int'(idx0)*8 +: 8];
            i0  <= req_data[int'(idx0)*WID +: WID];
         end
         if (v1) begin
            wa1 <= req_wa[int'(idx1)*A +: A];
            we1 <= req_we[int'(idx1)*8 +: 8];
            i1  <= req_data[int'(idx1)*WID +: WID];
         end
         if (v2) begin
            wa2 <= req_wa[int'(idx2)*A +: A];
            we2 <= req_we[int'(idx2)*8 +: 8];
            i2  <= req_data[int'(idx2)*WID +: WID];
         end
      end
   end

endmodule

// File: tb/tb_thor2025_rf_wrport_sched.sv
// Directed bench for the RF write-port scheduler with hand-computed
// expectations for grant order, port mapping, stall and reset behaviour.
module tb_thor2025_rf_wrport_sched;

   localparam int WID  = 64;
   localparam int RBIT = 11;
   localparam int NREQ = 6;
   localparam int A    = RBIT + 1;

   logic                     clk;
   logic                     rst;
   logic                     stall;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ*A-1:0]        req_wa;
   logic [NREQ*8-1:0]        req_we;
   logic [NREQ*WID-1:0]      req_data;
   logic                     wr0, wr1, wr2;
   logic [RBIT:0]            wa0, wa1, wa2;
   logic [7:0]               we0, we1, we2;
   logic [WID-1:0]           i0, i1, i2;
   logic [31:0]              stall_cnt;

   int passed = 0;
   int total  = 0;

   thor2025_rf_wrport_sched #(
      .WID  (WID),
      .RBIT (RBIT),
      .NREQ (NREQ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wa    (req_wa),
      .req_we    (req_we),
      .req_data  (req_data),
      .wr0       (wr0),
      .wr1       (wr1),
      .wr2       (wr2),
      .wa0       (wa0),
      .wa1       (wa1),
      .wa2       (wa2),
      .we0       (we0),
      .we1       (we1),
      .we2       (we2),
      .i0        (i0),
      .i1        (i1),
      .i2        (i2),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_wa(input int i, input logic [RBIT:0] v);
      req_wa[i*A +: A] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] dat(input int i);
      return {32'hDA7A0000, 32'(i)};
   endfunction

   initial begin
      rst       = 1'b1;
      stall     = 1'b0;
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         set_wa(i, 12'(i + 1));
         req_we[i*8 +: 8]     = 8'(1 << i);
         req_data[i*WID +: WID] = dat(i);
      end
      #1;
      chk("rst_wr0", 64'(wr0), 64'd0);
      chk("rst_wa0", 64'(wa0), 64'd0);
      chk("rst_i0", i0, 64'd0);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;

      // three distinct requesters from pointer 0
      req_valid = 6'b000111;
      #1 chk("b_ready", 64'(req_ready), 64'b000111);
      tick();
      chk("b_wr", 64'({wr0, wr1, wr2}), 64'b111);
      chk("b_wa0", 64'(wa0), 64'd1);
      chk("b_wa1", 64'(wa1), 64'd2);
      chk("b_wa2", 64'(wa2), 64'd3);
      chk("b_i0", i0, dat(0));
      chk("b_we1", 64'(we1), 64'h02);
      chk("b_cnt", 64'(stall_cnt), 64'd0);

      // all valid: pointer now 3
      @(negedge clk);
      req_valid = 6'b111111;
      #1 chk("f1_ready", 64'(req_ready), 64'b111000);
      tick();
      chk("f1_wr", 64'({wr0, wr1, wr2}), 64'b111);
      chk("f1_wa0", 64'(wa0), 64'd4);
      chk("f1_wa2", 64'(wa2), 64'd6);
      chk("f1_cnt", 64'(stall_cnt), 64'd1);
      @(negedge clk);
      #1 chk("f2_ready", 64'(req_ready), 64'b000111);
      tick();
      chk("f2_wa0", 64'(wa0), 64'd1);
      chk("f2_cnt", 64'(stall_cnt), 64'd2);
      @(negedge clk);
      #1 chk("f3_ready", 64'(req_ready), 64'b111000);
      tick();
      chk("f3_i2", i2, dat(5));
      chk("f3_cnt", 64'(stall_cnt), 64'd3);

      // duplicate does not use up one of the three slots
      @(negedge clk);
      req_valid = 6'b001111;
      set_wa(1, 12'd1);
      #1 chk("d_ready", 64'(req_ready), 64'b001101);
      tick();
      chk("d_wa0", 64'(wa0), 64'd1);
      chk("d_wa1", 64'(wa1), 64'd3);
      chk("d_wa2", 64'(wa2), 64'd4);
      chk("d_cnt", 64'(stall_cnt), 64'd4);

      // same address on two requesters, pointer 4
      @(negedge clk);
      req_valid = 6'b000011;
      set_wa(0, 12'd5);
      set_wa(1, 12'd5);
      #1 chk("s_ready", 64'(req_ready), 64'b000001);
      tick();
      chk("s_wr", 64'({wr0, wr1, wr2}), 64'b100);
      chk("s_wa0", 64'(wa0), 64'd5);
      chk("s_i0", i0, dat(0));
      chk("s_cnt", 64'(stall_cnt), 64'd5);
      @(negedge clk);
      req_valid = 6'b000010;
      #1 chk("s2_ready", 64'(req_ready), 64'b000010);
      tick();
      chk("s2_wr", 64'({wr0, wr1, wr2}), 64'b100);
      chk("s2_i0", i0, dat(1));
      chk("s2_cnt", 64'(stall_cnt), 64'd5);

      // null-register write consumed without a port
      @(negedge clk);
      req_valid = 6'b000001;
      set_wa(0, 12'h040);
      #1 chk("z_ready", 64'(req_ready), 64'b000001);
      tick();
      chk("z_wr", 64'({wr0, wr1, wr2}), 64'b000);

      // stall for three cycles
      @(negedge clk);
      stall     = 1'b1;
      req_valid = 6'b100000;
      for (int c = 0; c < 3; c++) begin
         #1 chk("st_ready", 64'(req_ready), 64'd0);
         tick();
         chk("st_wr", 64'({wr0, wr1, wr2}), 64'b000);
         @(negedge clk);
      end
      chk("st_cnt", 64'(stall_cnt), 64'd8);
      stall = 1'b0;
      #1 chk("sd_ready", 64'(req_ready), 64'b100000);
      tick();
      chk("sd_wr", 64'({wr0, wr1, wr2}), 64'b100);
      chk("sd_wa0", 64'(wa0), 64'd6);
      chk("sd_cnt", 64'(stall_cnt), 64'd8);

      // pointer back at 0, then reset mid-cycle
      @(negedge clk);
      set_wa(0, 12'd1);
      set_wa(1, 12'd2);
      req_valid = 6'b111111;
      #1 chk("p_ready", 64'(req_ready), 64'b000111);
      #2 rst = 1'b1;
      #1;
      chk("r_wr", 64'({wr0, wr1, wr2}), 64'b000);
      chk("r_wa0", 64'(wa0), 64'd0);
      chk("r_i0", i0, 64'd0);
      chk("r_cnt", 64'(stall_cnt), 64'd0);
      chk("r_ready", 64'(req_ready), 64'b000111);
      tick();
      chk("r_hold", 64'({wr0, wr1, wr2}), 64'b000);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("r_post_wr", 64'({wr0, wr1, wr2}), 64'b000);
      chk("r_post_ready", 64'(req_ready), 64'b000111);
      tick();
      chk("r_g_wr", 64'({wr0, wr1, wr2}), 64'b111);
      chk("r_g_wa0", 64'(wa0), 64'd1);
      chk("r_g_wa1", 64'(wa1), 64'd2);
      chk("r_g_wa2", 64'(wa2), 64'd3);
      chk("r_g_cnt", 64'(stall_cnt), 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
